// File: rtl/shift_sequencer.sv
// Iterative shifter front-end: steps an external 1-bit shift unit (su) once per
// cycle, feeding its output back, until the requested distance is covered.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] su_a,
    output logic [1:0]       su_select,
    input  logic [WIDTH-1:0] su_out,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Handshake: a request is taken on a rising edge where start=1 and the
    // sequencer is not busy; done pulses for one cycle when result is valid.
    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         op_q;
    logic               busy_q;
    logic               done_q;

    assign cnt_d = cnt_q - 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FINISH: begin
                    if (start) begin
                        acc_q <= operand;
                        op_q  <= op;
                        cnt_q <= amount;
                        if (amount == '0) begin
                            // Zero distance bypasses the shift unit entirely.
                            result_q <= operand;
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_q <= su_out;
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= su_out;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= FINISH;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign su_a      = acc_q;
    assign su_select = op_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: single-step su behaviour plus a whole-shift
// reference model compared every cycle, with directed literal cases.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  amount;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] su_a;
    logic [1:0]  su_select;
    logic [31:0] su_out;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .amount    (amount),
        .operand   (operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .su_a      (su_a),
        .su_select (su_select),
        .su_out    (su_out),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-position shift unit
    always_comb begin
        su_out = su_a << 1;
        if (su_select[1]) begin
            if (su_select[0]) su_out = {1'b0, su_a[31:1]};
            else              su_out = {su_a[31], su_a[31:1]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] full_shift(input logic [31:0] v, input logic [1:0] o, input int n);
        if (!o[1])     return v << n;
        else if (!o[0]) return 32'($signed(v) >>> n);
        else           return v >> n;
    endfunction

    // reference model: whole-request view, no per-step state
    int          cyc       = 0;
    int          acc_edge  = 0;
    int          m_n       = 0;
    bit          m_pending = 0;
    logic [31:0] m_operand = '0;
    logic [1:0]  m_op      = '0;
    logic [31:0] m_target  = '0;
    logic [31:0] m_res     = '0;
    logic        m_busy    = 0;
    logic        m_done    = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        bit was_busy;
        int j;
        was_busy = m_pending && ((cyc - acc_edge) < m_n);
        cyc++;
        if (!rst_n) begin
            m_pending = 0;
            m_res     = '0;
            exp_q.delete();
        end else if (start && !was_busy) begin
            acc_edge  = cyc;
            m_n       = int'(amount);
            m_operand = operand;
            m_op      = op;
            m_target  = full_shift(operand, op, int'(amount));
            m_pending = 1;
            exp_q.push_back(m_target);
        end
        j      = cyc - acc_edge;
        m_busy = m_pending && (j < m_n);
        m_done = m_pending && (j == m_n);
        if (m_done) m_res = m_target;
    end

    // compare process: every cycle after the outputs settle
    always @(posedge clk) begin
        #2;
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        check("done", {31'b0, done}, {31'b0, m_done});
        check("result", result, m_res);
        if (m_busy) begin
            check("su_a", su_a, full_shift(m_operand, m_op, cyc - acc_edge));
            check("su_select", {30'b0, su_select}, {30'b0, m_op});
        end
        if (done && exp_q.size() != 0) check("queue_result", result, exp_q.pop_front());
    end

    // driver tasks
    task automatic drive_req(input logic [31:0] v, input logic [1:0] o, input logic [4:0] n);
        @(negedge clk);
        start = 1'b1; operand = v; op = o; amount = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #3;
            if (busy) busy_cycles++;
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [31:0] v, input logic [1:0] o,
                            input logic [4:0] n, input logic [31:0] exp_res, input int exp_busy);
        int  bc;
        bit  seen;
        drive_req(v, o, n);
        // drive_req already consumed the accept edge; count it back in
        bc = busy ? 1 : 0;
        if (done) begin
            seen = 1;
        end else begin
            int more;
            wait_done(40, more, seen);
            bc += more;
        end
        if (seen) check({name, "_result"}, result, exp_res);
        check({name, "_busy_cycles"}, bc, exp_busy);
    endtask

    initial begin
        int  bc;
        bit  seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; amount = '0; operand = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        directed("t1_zero", 32'hDEADBEEF, 2'b00, 5'd0, 32'hDEADBEEF, 0);
        directed("t2_left4", 32'h000000F1, 2'b00, 5'd4, 32'h00000F10, 4);
        directed("t3_arith8", 32'h80000000, 2'b10, 5'd8, 32'hFF800000, 8);
        directed("t3_logic8", 32'h80000000, 2'b11, 5'd8, 32'h00800000, 8);
        directed("t4_logic31", 32'h80000000, 2'b11, 5'd31, 32'h00000001, 31);
        directed("op01_left", 32'h00000003, 2'b01, 5'd2, 32'h0000000C, 2);

        // start while busy is ignored
        drive_req(32'h00000003, 2'b00, 5'd10);
        repeat (2) @(negedge clk);
        drive_req(32'h0000FFFF, 2'b11, 5'd1);
        wait_done(40, bc, seen);
        if (seen) check("t5_ignore_result", result, 32'h00000C00);
        repeat (3) @(negedge clk);

        // reset in the middle of a shift abandons it
        drive_req(32'h12345678, 2'b10, 5'd20);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_done", {31'b0, done}, 32'd0);
        check("t5_rst_result", result, 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #3;
            if (done) seen = 1;
        end
        check("t5_no_done_after_rst", {31'b0, seen}, 32'd0);

        // back-to-back: new start sampled in the FINISH cycle
        drive_req(32'h00000001, 2'b00, 5'd1);
        wait_done(10, bc, seen);
        if (seen) check("t6_first_result", result, 32'h00000002);
        @(negedge clk);
        start = 1'b1; operand = 32'h00000030; op = 2'b11; amount = 5'd2;
        @(negedge clk);
        start = 1'b0;
        check("t6_second_busy", {31'b0, busy}, 32'd1);
        wait_done(10, bc, seen);
        if (seen) check("t6_second_result", result, 32'h0000000C);

        // randomized traffic, including starts while busy and rare resets
        repeat (600) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 149) != 0);
            start   = ($urandom_range(0, 2) == 0);
            op      = 2'($urandom_range(0, 3));
            amount  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
            operand = $urandom;
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
